keypad_matrix_emulator: RTL and testbench

KEYPAD_MATRIX_EMULATOR -- requirements
Module: keypad_matrix_emulator

---
 rtl/keypad_matrix_emulator.sv | 159 +++++++++++++++
 tb/tb_keypad_matrix_emulator.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_matrix_emulator.sv
// rtl/keypad_matrix_emulator.sv - emulates one key of a 3x3 matrix keypad pressed and released on command
// Optional contact bounce phases driven by an LFSR are built only when KEYPAD_EMU_BOUNCE_EN is defined.
module keypad_matrix_emulator #(
  parameter int         BOUNCE_CYCLES = 16,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_key,
  input  logic [15:0] cmd_hold,
  input  logic        abort,
  input  logic [2:0]  column,
  output logic [2:0]  row,
  output logic        contact,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, DONE} state_t;

  if (BOUNCE_CYCLES < 1 || BOUNCE_CYCLES > 255 || LFSR_SEED == 8'h00) begin : g_param_check
    $error("keypad_matrix_emulator: BOUNCE_CYCLES must be 1..255 and LFSR_SEED nonzero");
  end

  state_t      state, state_nxt;
  logic [3:0]  key_q;
  logic [15:0] hold_q;
  logic [15:0] cnt, cnt_nxt;
  logic        err_q, err_nxt;
  logic        contact_nxt;
  logic [1:0]  key_col, key_row;
  logic [15:0] hold_last;
  logic        col_sel;

  assign key_col   = key_q[3:2];
  assign key_row   = key_q[1:0];
  assign hold_last = (hold_q == 16'd0) ? 16'd0 : hold_q - 16'd1;

`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam logic [15:0] BOUNCE_LAST = 16'(BOUNCE_CYCLES - 1);

  logic [7:0] lfsr, lfsr_step;
  assign lfsr_step = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

  // The LFSR steps on every edge that lands in a bounce state, so the
  // registered contact always equals the current lfsr[0] while bouncing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr <= LFSR_SEED;
    else if (state_nxt == BOUNCE_IN || state_nxt == BOUNCE_OUT) lfsr <= lfsr_step;
  end
`endif

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    err_nxt     = err_q;
    contact_nxt = 1'b0;
    cmd_ready   = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cnt_nxt = 16'd0;
          if (cmd_key[3:2] == 2'd3 || cmd_key[1:0] == 2'd3) begin
            err_nxt   = 1'b1;
            state_nxt = DONE;
          end else begin
            err_nxt = 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
            state_nxt = BOUNCE_IN;
`else
            state_nxt = HOLD;
`endif
          end
        end
      end
`ifdef KEYPAD_EMU_BOUNCE_EN
      BOUNCE_IN: begin
        if (abort) state_nxt = DONE;
        else if (cnt == BOUNCE_LAST) begin
          state_nxt = HOLD;
          cnt_nxt   = 16'd0;
        end else cnt_nxt = cnt + 16'd1;
      end
      BOUNCE_OUT: begin
        if (abort) state_nxt = DONE;
        else if (cnt == BOUNCE_LAST) state_nxt = DONE;
        else cnt_nxt = cnt + 16'd1;
      end
`endif
      HOLD: begin
        if (abort) state_nxt = DONE;
        else if (cnt == hold_last) begin
          cnt_nxt = 16'd0;
`ifdef KEYPAD_EMU_BOUNCE_EN
          state_nxt = BOUNCE_OUT;
`else
          state_nxt = DONE;
`endif
        end else cnt_nxt = cnt + 16'd1;
      end
      DONE: begin
        state_nxt = IDLE;
        cnt_nxt   = 16'd0;
      end
      default: state_nxt = IDLE;
    endcase

    if (state_nxt == HOLD) contact_nxt = 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
    if (state_nxt == BOUNCE_IN || state_nxt == BOUNCE_OUT) contact_nxt = lfsr_step[0];
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 16'd0;
      err_q   <= 1'b0;
      contact <= 1'b0;
      key_q   <= 4'd0;
      hold_q  <= 16'd0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      err_q   <= err_nxt;
      contact <= contact_nxt;
      if (cmd_valid && cmd_ready) begin
        key_q  <= cmd_key;
        hold_q <= cmd_hold;
      end
    end
  end

  assign done = (state == DONE);
  assign err  = done & err_q;

  // Only the pressed key's column is looked at, so no ghost rows appear.
  always_comb begin
    row = 3'b111;
    case (key_col)
      2'd0:    col_sel = column[0];
      2'd1:    col_sel = column[1];
      2'd2:    col_sel = column[2];
      default: col_sel = 1'b1;
    endcase
    if (contact && !col_sel) begin
      case (key_row)
        2'd0:    row[0] = 1'b0;
        2'd1:    row[1] = 1'b0;
        2'd2:    row[2] = 1'b0;
        default: row    = 3'b111;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// tb/tb_keypad_matrix_emulator.sv - scoreboard bench for keypad_matrix_emulator
// Covers both builds; bounce expectations apply when KEYPAD_EMU_BOUNCE_EN is defined.
module tb_keypad_matrix_emulator;

`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int NB = 16;
`else
  localparam int NB = 0;
`endif

  // {cmd_ready, contact, row[2:0], done, err}
  localparam logic [6:0] IDLE_V   = 7'b1_0_111_0_0;
  localparam logic [6:0] DONE_OK  = 7'b0_0_111_1_0;
  localparam logic [6:0] DONE_ERR = 7'b0_0_111_1_1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  cmd_key = 4'd0;
  logic [15:0] cmd_hold = 16'd0;
  logic [2:0]  column = 3'b111;
  logic        cmd_ready, contact, done, err;
  logic [2:0]  row;

  keypad_matrix_emulator #(.BOUNCE_CYCLES(16), .LFSR_SEED(8'hA5)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_key(cmd_key), .cmd_hold(cmd_hold), .abort(abort), .column(column),
    .row(row), .contact(contact), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] id;
    logic [7:0] cyc;
    logic [6:0] v;
  } exp_t;

  exp_t       exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] tb_lfsr = 8'hA5;

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  task automatic push_v(input logic [7:0] id, input int cyc, input logic [6:0] v);
    exp_t e;
    e.id = id; e.cyc = 8'(cyc); e.v = v;
    exp_q.push_back(e);
  endtask

  task automatic push_act(input logic [7:0] id, input int cyc, input logic ct, input logic [2:0] act_row);
    push_v(id, cyc, {1'b0, ct, (ct ? act_row : 3'b111), 2'b00});
  endtask

  // Expected cycle trace of one press starting with the IDLE accept cycle (cycle 0).
  task automatic push_press(input logic [7:0] id, input int hold, input logic [2:0] act_row,
                            input bit inval, input int abort_at);
    int c;
    bit stop;
    int hold_eff;
    push_v(id, 0, IDLE_V);
    if (inval) begin
      push_v(id, 1, DONE_ERR);
      return;
    end
    c = 1; stop = 0;
    hold_eff = (hold == 0) ? 1 : hold;
    for (int i = 0; i < NB; i++) if (!stop) begin
      tb_lfsr = lfsr_next(tb_lfsr);
      push_act(id, c, tb_lfsr[0], act_row);
      stop = (abort_at == c); c++;
    end
    for (int i = 0; i < hold_eff; i++) if (!stop) begin
      push_act(id, c, 1'b1, act_row);
      stop = (abort_at == c); c++;
    end
    for (int i = 0; i < NB; i++) if (!stop) begin
      tb_lfsr = lfsr_next(tb_lfsr);
      push_act(id, c, tb_lfsr[0], act_row);
      stop = (abort_at == c); c++;
    end
    push_v(id, c, DONE_OK);
  endtask

  task automatic check_now(input logic [7:0] id, input logic [6:0] exp_v);
    logic [6:0] got;
    got = {cmd_ready, contact, row, done, err};
    vectors++;
    if (got !== exp_v) begin
      miscompares++;
      $display("FAIL immediate id%0d: got {rdy,ct,row,done,err}=%b required %b", id, got, exp_v);
    end
  endtask

  task automatic wait_drain(input logic [7:0] id);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0) break;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain id%0d: %0d expectations left, required 0", id, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_press(input logic [7:0] id, input logic [3:0] key, input int hold,
                          input logic [2:0] col_v, input logic [2:0] act_row,
                          input bit inval, input int abort_at);
    @(posedge clk); #1;
    column = col_v; cmd_key = key; cmd_hold = 16'(hold); cmd_valid = 1'b1;
    push_press(id, hold, act_row, inval, abort_at);
    @(posedge clk); #1;
    cmd_valid = 1'b0; abort = 1'b0;
    if (abort_at > 0) begin
      repeat (abort_at - 1) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
    end
    wait_drain(id);
  endtask

  // Monitor: one expectation per sampled cycle, checked mid-cycle.
  always @(negedge clk) begin
    exp_t       e;
    logic [6:0] got;
    if (reset && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = {cmd_ready, contact, row, done, err};
      vectors++;
      if (got !== e.v) begin
        miscompares++;
        $display("FAIL id%0d cyc%0d: got {rdy,ct,row,done,err}=%b required %b", e.id, e.cyc, got, e.v);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #12 check_now(0, IDLE_V);
    @(posedge clk); #1 reset = 1'b1;
    push_v(0, 0, IDLE_V);
    wait_drain(0);

    abort = 1'b1;  // ignored while IDLE
    do_press(1, 4'b0110, 5, 3'b101, 3'b011, 0, 0);
    do_press(2, 4'b0110, 5, 3'b110, 3'b111, 0, 0);
    do_press(3, 4'b0011, 5, 3'b000, 3'b111, 1, 0);
    do_press(4, 4'b1100, 5, 3'b000, 3'b111, 1, 0);
    do_press(5, 4'b1010, 0, 3'b011, 3'b011, 0, 0);

    // cmd_valid held high through a press; second command must wait for IDLE
    @(posedge clk); #1;
    column = 3'b100; cmd_key = 4'b0110; cmd_hold = 16'd3; cmd_valid = 1'b1;
    push_press(6, 3, 3'b011, 0, 0);
    push_press(7, 2, 3'b101, 0, 0);
    @(posedge clk); #1;
    cmd_key = 4'b0001; cmd_hold = 16'd2;
    repeat (2 * NB + 5) @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_drain(7);

    do_press(8, 4'b1001, 10, 3'b011, 3'b101, 0, NB + 2);

    // Reset dropped mid-HOLD: outputs clear without a clock edge, no done afterwards
    @(posedge clk); #1;
    column = 3'b101; cmd_key = 4'b0110; cmd_hold = 16'd20; cmd_valid = 1'b1;
    push_press(10, 20, 3'b011, 0, NB + 3);
    void'(exp_q.pop_back());
    @(posedge clk); #1 cmd_valid = 1'b0;
    wait_drain(10);
    #1 reset = 1'b0;
    #1 check_now(10, IDLE_V);
    @(posedge clk); #1 reset = 1'b1;
    tb_lfsr = 8'hA5;
    for (int i = 0; i < 3; i++) push_v(11, i, IDLE_V);
    wait_drain(11);

    do_press(12, 4'b0000, 2, 3'b110, 3'b110, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
